// File: rtl/crc_tx_pkg.sv
// Shared types and constants for the CRC frame transmitter.
// CRC_TX_PREAMBLE_EN adds an 8-bit preamble ahead of the payload.
package crc_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CRC_RUN  = 2'd1,
        CRC_WAIT = 2'd2,
        SEND     = 2'd3
    } state_t;

    localparam int         DATA_BITS     = 66;
    localparam int         CRC_BITS      = 16;
    localparam int         CRC_LAT       = 67;
    localparam int         CRC_TIMEOUT   = 4;
    localparam int         PREAMBLE_BITS = 8;
    localparam logic [7:0] PREAMBLE      = 8'hA5;
    localparam int         CNT_W         = 7;

`ifdef CRC_TX_PREAMBLE_EN
    localparam int HDR_BITS = PREAMBLE_BITS;
`else
    localparam int HDR_BITS = 0;
`endif
    localparam int FRAME_BITS = HDR_BITS + DATA_BITS + CRC_BITS;

    localparam logic [CNT_W-1:0] LAT_LAST     = CNT_W'(CRC_LAT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CRC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_BITS - 1);

    // Frame index 0 leaves the link first; the CRC goes out MSB first.
    function automatic logic [0:FRAME_BITS-1] build_frame(
        input logic [0:DATA_BITS-1] payload,
        input logic [CRC_BITS-1:0]  crc
    );
        logic [0:FRAME_BITS-1] f;
        f = '0;
`ifdef CRC_TX_PREAMBLE_EN
        for (int i = 0; i < PREAMBLE_BITS; i++) begin
            f[i] = PREAMBLE[PREAMBLE_BITS-1-i];
        end
`endif
        for (int i = 0; i < DATA_BITS; i++) begin
            f[HDR_BITS+i] = payload[i];
        end
        for (int i = 0; i < CRC_BITS; i++) begin
            f[HDR_BITS+DATA_BITS+i] = crc[CRC_BITS-1-i];
        end
        return f;
    endfunction

endpackage

// File: rtl/crc_frame_tx_piso.sv
// Frame-wide parallel-load shift register; bit 0 is the serial output.
module frame_piso
    import crc_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [0:FRAME_BITS-1] load_data,
    input  logic                  shift,
    output logic                  sout
);

    logic [0:FRAME_BITS-1] sr_r;

    // Load wins over shift; zeros fill in behind the departing bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r <= '0;
        end else if (load) begin
            sr_r <= load_data;
        end else if (shift) begin
            sr_r <= {sr_r[1:FRAME_BITS-1], 1'b0};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign sout = sr_r[0];

endmodule

// File: rtl/crc_frame_tx.sv
// Drives one CRC-16 engine computation per payload, then serialises payload + CRC on a valid/ready link.
// CRC_TX_PREAMBLE_EN (see crc_tx_pkg) prepends the preamble.
module crc_frame_tx
    import crc_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [0:DATA_BITS-1] data,
    output logic                 crc_en,
    input  logic [CRC_BITS-1:0]  crc_in,
    input  logic                 crc_done,
    output logic                 tx_bit,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_err
);

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_s;
    logic                 crc_en_r, crc_en_s;
    logic                 tx_valid_r, tx_valid_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 crc_err_r, crc_err_s;
    logic                 cap_s, load_s, shift_s;
    logic [0:DATA_BITS-1] payload_r;

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 7'd0;
            bit_cnt_r  <= 7'd0;
            crc_en_r   <= 1'b0;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            crc_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            crc_en_r   <= crc_en_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            crc_err_r  <= crc_err_s;
        end
    end

    // Payload is held for the whole transaction so the frame can be assembled once the CRC arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_r <= '0;
        end else if (cap_s) begin
            payload_r <= data;
        end else begin
            payload_r <= payload_r;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_cnt_s  = bit_cnt_r;
        crc_en_s   = crc_en_r;
        tx_valid_s = tx_valid_r;
        done_s     = 1'b0;
        crc_err_s  = 1'b0;
        cap_s      = 1'b0;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the finished frame and is dropped.
                if (start && !done_r) begin
                    cap_s    = 1'b1;
                    crc_en_s = 1'b1;
                    cnt_s    = 7'd0;
                    state_s  = CRC_RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            CRC_RUN: begin
                // The engine's bit counter only wraps if en lasts exactly CRC_LAT cycles.
                if (cnt_r == LAT_LAST) begin
                    crc_en_s = 1'b0;
                    cnt_s    = 7'd0;
                    state_s  = CRC_WAIT;
                end else begin
                    cnt_s    = cnt_r + 7'd1;
                end
            end
            CRC_WAIT: begin
                if (crc_done) begin
                    load_s     = 1'b1;
                    tx_valid_s = 1'b1;
                    bit_cnt_s  = 7'd0;
                    state_s    = SEND;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    crc_err_s  = 1'b1;
                    cnt_s      = 7'd0;
                    state_s    = IDLE;
                end else begin
                    cnt_s      = cnt_r + 7'd1;
                end
            end
            SEND: begin
                if (tx_valid_r && tx_ready) begin
                    shift_s = 1'b1;
                    if (bit_cnt_r == FRAME_LAST) begin
                        tx_valid_s = 1'b0;
                        done_s     = 1'b1;
                        bit_cnt_s  = 7'd0;
                        state_s    = IDLE;
                    end else begin
                        bit_cnt_s  = bit_cnt_r + 7'd1;
                    end
                end else begin
                    shift_s = 1'b0;
                end
            end
            default: begin
                crc_en_s   = 1'b0;
                tx_valid_s = 1'b0;
                state_s    = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    frame_piso u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (build_frame(payload_r, crc_in)),
        .shift     (shift_s),
        .sout      (tx_bit)
    );

    assign crc_en   = crc_en_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign crc_err  = crc_err_r;

endmodule
